// File: rtl/mem_pipe_responder.sv
// Fixed-latency pipelined memory model answering cache-fill reads and write-through stores.
// Reads return in issue order exactly LATENCY cycles after issue; writes are silent.
module mem_pipe_responder #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned LATENCY    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [3:0]        rd_pending
);

    localparam int unsigned Depth = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0]     mem_q [Depth];
    logic [DEPTH_LOG2-1:0] idx;
    logic                  rd_issue;
    logic                  wr_issue;

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [DATA_W-1:0]  data_q [LATENCY];
    logic [DATA_W-1:0]  data_d [LATENCY];
    logic [3:0]         pend_q, pend_d;

    // Byte-address LSB and bits above the array are dropped, so addresses alias.
    logic unused_addr;
    assign unused_addr = ^{addr[ADDR_W-1:DEPTH_LOG2+1], addr[0]};

    assign idx      = addr[DEPTH_LOG2:1];
    assign rd_issue = enable & ~wr;
    assign wr_issue = enable & wr;

    always_comb begin
        valid_d    = '0;
        valid_d[0] = rd_issue;
        data_d[0]  = rd_issue ? mem_q[idx] : '0;
        for (int i = 1; i < int'(LATENCY); i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_comb begin
        pend_d = pend_q + {3'b000, rd_issue} - {3'b000, data_valid};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            pend_q  <= '0;
        end else begin
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    // Payload is gated at the output by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(LATENCY); i++) begin
            data_q[i] <= data_d[i];
        end
    end

    // Storage deliberately survives reset.
    always_ff @(posedge clk) begin
        if (wr_issue) begin
            mem_q[idx] <= data_in;
        end
    end

    assign data_valid = valid_q[LATENCY-1];
    assign data_out   = data_valid ? data_q[LATENCY-1] : '0;
    assign rd_pending = pend_q;

endmodule

// File: tb/tb_mem_pipe_responder.sv
// Directed bench for mem_pipe_responder: per-cycle vector table plus hand-written
// sequences for read/write ordering, mid-flight reset and address aliasing.
module tb_mem_pipe_responder;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_valid;
    logic [3:0]  rd_pending;

    int n_checks = 0;
    int n_pass   = 0;

    mem_pipe_responder #(
        .DATA_W    (16),
        .ADDR_W    (16),
        .DEPTH_LOG2(10),
        .LATENCY   (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .wr        (wr),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_valid(data_valid),
        .rd_pending(rd_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  ep;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic w, input logic [15:0] a,
                         input logic [15:0] d);
        enable  = en;
        wr      = w;
        addr    = a;
        data_in = d;
    endtask

    function automatic vec_t mk(input string name, input logic en, input logic w,
                                input logic [15:0] a, input logic [15:0] d, input logic ev,
                                input logic [15:0] ed, input logic [3:0] ep);
        vec_t v;
        v.name = name; v.en = en; v.wr = w; v.addr = a; v.din = d;
        v.ev = ev; v.ed = ed; v.ep = ep;
        return v;
    endfunction

    initial begin
        bit saw_valid;

        // Test 2: write then read, exact latency and pending profile.
        vecs.push_back(mk("t2_wr",  1, 1, 16'h0010, 16'hBEEF, 0, 16'h0000, 4'd0));
        vecs.push_back(mk("t2_rd",  1, 0, 16'h0010, 16'h0000, 0, 16'h0000, 4'd1));
        vecs.push_back(mk("t2_c1",  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 4'd1));
        vecs.push_back(mk("t2_c2",  0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 4'd1));
        vecs.push_back(mk("t2_ret", 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF, 4'd1));
        vecs.push_back(mk("t2_end", 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 4'd0));
        // Test 3: burst of 8 reads of preloaded words 0x1000+i.
        vecs.push_back(mk("t3_k0",  1, 0, 16'h0100, 16'h0000, 0, 16'h0000, 4'd1));
        vecs.push_back(mk("t3_k1",  1, 0, 16'h0102, 16'h0000, 0, 16'h0000, 4'd2));
        vecs.push_back(mk("t3_k2",  1, 0, 16'h0104, 16'h0000, 0, 16'h0000, 4'd3));
        vecs.push_back(mk("t3_k3",  1, 0, 16'h0106, 16'h0000, 1, 16'h1000, 4'd4));
        vecs.push_back(mk("t3_k4",  1, 0, 16'h0108, 16'h0000, 1, 16'h1001, 4'd4));
        vecs.push_back(mk("t3_k5",  1, 0, 16'h010A, 16'h0000, 1, 16'h1002, 4'd4));
        vecs.push_back(mk("t3_k6",  1, 0, 16'h010C, 16'h0000, 1, 16'h1003, 4'd4));
        vecs.push_back(mk("t3_k7",  1, 0, 16'h010E, 16'h0000, 1, 16'h1004, 4'd4));
        vecs.push_back(mk("t3_k8",  0, 0, 16'h0000, 16'h0000, 1, 16'h1005, 4'd3));
        vecs.push_back(mk("t3_k9",  0, 0, 16'h0000, 16'h0000, 1, 16'h1006, 4'd2));
        vecs.push_back(mk("t3_k10", 0, 0, 16'h0000, 16'h0000, 1, 16'h1007, 4'd1));
        vecs.push_back(mk("t3_k11", 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 4'd0));

        rst_n = 1'b0;
        drive(0, 0, 16'h0000, 16'h0000);
        tick();
        tick();
        chk("in_reset_valid", {31'd0, data_valid}, 32'd0);
        chk("in_reset_pending", {28'd0, rd_pending}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Preload storage, then reset to show contents survive.
        drive(1, 1, 16'h0020, 16'h1111);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 16'h0100 + 16'(2 * i), 16'h1000 + 16'(i));
            tick();
        end
        drive(0, 0, 16'h0000, 16'h0000);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("t1_valid", {31'd0, data_valid}, 32'd0);
        chk("t1_data", {16'd0, data_out}, 32'd0);
        chk("t1_pending", {28'd0, rd_pending}, 32'd0);

        foreach (vecs[i]) begin
            drive(vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din);
            tick();
            chk({vecs[i].name, "_valid"}, {31'd0, data_valid}, {31'd0, vecs[i].ev});
            chk({vecs[i].name, "_data"}, {16'd0, data_out}, {16'd0, vecs[i].ed});
            chk({vecs[i].name, "_pending"}, {28'd0, rd_pending}, {28'd0, vecs[i].ep});
        end

        // Test 4: read captures old value; write right after; later read sees new.
        drive(1, 0, 16'h0020, 16'h0000);
        tick();
        drive(1, 1, 16'h0020, 16'h2222);
        tick();
        drive(1, 0, 16'h0020, 16'h0000);
        tick();
        drive(0, 0, 16'h0000, 16'h0000);
        tick();
        chk("t4_old_valid", {31'd0, data_valid}, 32'd1);
        chk("t4_old_data", {16'd0, data_out}, 32'h1111);
        tick();
        chk("t4_gap_valid", {31'd0, data_valid}, 32'd0);
        chk("t4_gap_data", {16'd0, data_out}, 32'd0);
        tick();
        chk("t4_new_valid", {31'd0, data_valid}, 32'd1);
        chk("t4_new_data", {16'd0, data_out}, 32'h2222);
        tick();
        chk("t4_pending", {28'd0, rd_pending}, 32'd0);

        // Test 5: reset with three reads in flight.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 16'h0010, 16'h0000);
            tick();
        end
        chk("t5_pre_pending", {28'd0, rd_pending}, 32'd3);
        drive(0, 0, 16'h0000, 16'h0000);
        rst_n = 1'b0;
        #1;
        chk("t5_async_pending", {28'd0, rd_pending}, 32'd0);
        tick();
        rst_n = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (data_valid) saw_valid = 1'b1;
        end
        chk("t5_no_return", {31'd0, saw_valid}, 32'd0);
        chk("t5_pending", {28'd0, rd_pending}, 32'd0);
        drive(1, 0, 16'h0010, 16'h0000);
        tick();
        drive(0, 0, 16'h0000, 16'h0000);
        tick();
        tick();
        tick();
        chk("t5_keep_valid", {31'd0, data_valid}, 32'd1);
        chk("t5_keep_data", {16'd0, data_out}, 32'hBEEF);

        // Test 6: odd address, upper bit aliases onto word 0.
        drive(1, 1, 16'h0801, 16'hA5A5);
        tick();
        drive(1, 0, 16'h0000, 16'h0000);
        tick();
        drive(0, 0, 16'h0000, 16'h0000);
        tick();
        tick();
        tick();
        chk("t6_alias_valid", {31'd0, data_valid}, 32'd1);
        chk("t6_alias_data", {16'd0, data_out}, 32'hA5A5);
        tick();
        chk("t6_pending", {28'd0, rd_pending}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
